avalon_mem_responder: RTL and testbench
=======================================

# avalon_mem_responder

Avalon-MM slave memory that answers the CPU's data/instruction master: word-addressed storage, byte-enable writes, and a configurable number of `waitrequest` stall cycles per transfer. Sits on the far side of the CPU bus in every system-level bench and replaces ad-hoc RAM models. Also provides a synchronous preload port so benches can write program words before releasing the CPU.

## Interface
Parameters:
- `DEPTH_LOG2`, 6: memory holds 2^DEPTH_LOG2 32-bit words.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0.
- `WAIT_CYCLES`, 1: stall cycles per transfer; legal range 1..15.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `reset`  in  1  asynchronous, active-high.
- `address`  in  32  byte address from the master; bits [1:0] ignored.
- `read`  in  1  read request.
- `write`  in  1  write request.
- `writedata`  in  32  write data.
- `byteenable`  in  4  lane enables; bit i selects writedata[8i+7:8i].
- `waitrequest`  out  1  stall; the transfer completes in the cycle where it is low.
- `readdata`  out  32  read data, valid in the completing cycle.
- `inst_input`  in  1  preload strobe.
- `inst_addr`  in  8  preload byte offset from BASE_ADDR; bits [1:0] ignored.
- `instruction`  in  32  preload word.
- `protocol_err`  out  1  sticky master-misbehaviour flag.

## Operation
- FSM states: IDLE, BUSY, ACK.
- `waitrequest` = (read|write) && state != ACK (combinational). It is low when there is no request.
- IDLE: on read|write, latch address, op, writedata, and byteenable. The IDLE cycle counts as the first stall cycle. Go to ACK if WAIT_CYCLES==1, else go to BUSY with the counter set to WAIT_CYCLES-2.
- BUSY: counter==0 → ACK, else decrement.
- ACK: the transfer completes.
  - Read: `readdata` already holds the word registered on entry to ACK.
  - Write: enabled lanes are committed at the end of the ACK cycle.
  - Next state is always IDLE. A back-to-back request is accepted from IDLE on the following cycle.
- Word index = (latched address - BASE_ADDR) >> 2.
- Out of range (index ≥ 2^DEPTH_LOG2, or address below BASE_ADDR): the read returns 0, the write is dropped, and `protocol_err` is set. The handshake still completes normally.
- read && write together: treated as a write; `protocol_err` set.
- Master drops read/write in BUSY or ACK before completion: abort to IDLE, no memory effect, `protocol_err` set.
- Address or op changes while waitrequest is high: the latched values are used; `protocol_err` set.
- Preload: when `inst_input`=1, mem[inst_addr>>2] ← instruction at the clock edge, all lanes.
  - Allowed in any state.
  - If it targets the same word as a committing bus write, the preload wins.
- `byteenable` is ignored on reads; the full word is returned.
- `byteenable`=0 on a write completes the handshake with no memory change.

## Timing
- Reset values: state IDLE, counter 0, `readdata` 0, `protocol_err` 0, all memory words 0.
- `waitrequest` follows read|write combinationally during reset.
- Latency: a request presented at cycle t completes at cycle t+WAIT_CYCLES. Throughput is one transfer per WAIT_CYCLES+1 cycles.
- Read-after-write to the same word: the next transfer sees the new data.
- Reset mid-transfer: immediate return to IDLE. The pending write is not committed.
- `protocol_err` clears only on reset.

## Structure
- Package `avalon_mem_pkg`: state enum (IDLE/BUSY/ACK), WAIT counter width (4), word/lane constants.
- One sub-module, `avalon_mem_array`: 2^DEPTH_LOG2 × 32 flop array with a byte-lane write port, a full-word preload port (priority), one registered read port, and async clear.
- The FSM, latching, and range/error checks live in the top module.

## Test plan
- Preload 0x04←0x24020010 and 0x08←0x1C600002, then read 0x04 with WAIT_CYCLES=1 → waitrequest high for 1 cycle; readdata=0x24020010 in the completing cycle.
- WAIT_CYCLES=3: write 0xDEADBEEF to 0x10 with byteenable=4'b0101, then read 0x10 → waitrequest high for 3 cycles each; read returns 0x00AD00EF.
- Back-to-back reads of 0x04 and 0x08 with read held high → completions exactly WAIT_CYCLES+1 cycles apart; correct data each time.
- Read 0x400 (out of range, DEPTH_LOG2=6) → completes with readdata=0; protocol_err=1 and stays high.
- Read and write asserted together at 0x20, data 0x11223344, byteenable=4'hF → the word is written; protocol_err=1.
- Assert reset during BUSY of a write to 0x0C → FSM returns to IDLE; a subsequent read of 0x0C returns 0; protocol_err=0.

Source files
------------

// File: rtl/avalon_mem_pkg.sv
`default_nettype none
// ==========================================================================
// avalon_mem_pkg : state encoding and bus constants for the responder   rev 1.0
// ==========================================================================
package avalon_mem_pkg;

  localparam int WORD_W = 32;
  localparam int LANES  = 4;
  localparam int CNT_W  = 4;

  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/avalon_mem_array.sv
`default_nettype none
// ==========================================================================
// avalon_mem_array : word flop array, byte-lane write, priority preload  rev 1.0
// ==========================================================================
module avalon_mem_array
  import avalon_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_idx,
  input  logic [WORD_W-1:0]     wr_data,
  input  logic [LANES-1:0]      wr_be,
  input  logic                  pre_en,
  input  logic [DEPTH_LOG2-1:0] pre_idx,
  input  logic [WORD_W-1:0]     pre_data,
  input  logic                  rd_en,
  input  logic                  rd_zero,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output logic [WORD_W-1:0]     rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        // Preload shadows a bus write landing on the same word in the same cycle.
        if (pre_en && (pre_idx == DEPTH_LOG2'(i))) begin
          mem[i] <= pre_data;
        end else if (wr_en && (wr_idx == DEPTH_LOG2'(i))) begin
          for (int b = 0; b < LANES; b++) begin
            if (wr_be[b]) mem[i][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
      if (rd_en) rd_data <= rd_zero ? '0 : mem[rd_idx];
    end
  end

endmodule
`default_nettype wire

// File: rtl/avalon_mem_responder.sv
`default_nettype none
// ==========================================================================
// avalon_mem_responder : Avalon-MM slave memory with programmable stalls rev 1.0
// ==========================================================================
module avalon_mem_responder
  import avalon_mem_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 6,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  input  logic        inst_input,
  input  logic [7:0]  inst_addr,
  input  logic [31:0] instruction,
  output logic        protocol_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        lat_addr;
  logic               lat_rd;
  logic               lat_wr;
  logic [WORD_W-1:0]  lat_wdata;
  logic [LANES-1:0]   lat_be;

  logic        req;
  logic [31:0] cur_addr;
  logic        cur_wr;
  logic [29:0] cur_word;
  logic        in_range;
  logic        enter_ack;
  logic        bus_changed;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] pre_word;
  logic        pre_en;
  logic        unused_bits;

  assign req         = read | write;
  assign waitrequest = req && (state != ACK);

  // In IDLE the live bus is the transfer being accepted; afterwards the latched copy rules.
  assign cur_addr = (state == IDLE) ? address : lat_addr;
  assign cur_wr   = (state == IDLE) ? write   : lat_wr;
  assign cur_word = cur_addr[31:2] - BASE_ADDR[31:2];
  assign in_range = (cur_addr[31:2] >= BASE_ADDR[31:2]) && (cur_word < 30'(DEPTH));

  assign enter_ack   = req && (((state == IDLE) && (WAIT_CYCLES == 1)) ||
                               ((state == BUSY) && (cnt == '0)));
  assign rd_en       = enter_ack && !cur_wr;
  assign wr_en       = (state == ACK) && req && lat_wr && in_range;
  assign bus_changed = (address != lat_addr) || (read != lat_rd) || (write != lat_wr);

  assign pre_word = {26'd0, inst_addr[7:2]};
  assign pre_en   = inst_input && (pre_word < 32'(DEPTH));

  assign unused_bits = ^{cur_addr[1:0], inst_addr[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_addr     <= '0;
      lat_rd       <= 1'b0;
      lat_wr       <= 1'b0;
      lat_wdata    <= '0;
      lat_be       <= '0;
      protocol_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            lat_addr  <= address;
            lat_rd    <= read;
            lat_wr    <= write;
            lat_wdata <= writedata;
            lat_be    <= byteenable;
            if ((read && write) || !in_range) protocol_err <= 1'b1;
            if (WAIT_CYCLES == 1) begin
              state <= ACK;
            end else begin
              state <= BUSY;
              cnt   <= CNT_W'(WAIT_CYCLES - 2);
            end
          end
        end
        BUSY: begin
          if (!req) begin
            state        <= IDLE;
            protocol_err <= 1'b1;
          end else begin
            if (bus_changed) protocol_err <= 1'b1;
            if (cnt == '0) state <= ACK;
            else           cnt   <= cnt - CNT_W'(1);
          end
        end
        ACK: begin
          if (!req) protocol_err <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  avalon_mem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_idx   (cur_word[DEPTH_LOG2-1:0]),
    .wr_data  (lat_wdata),
    .wr_be    (lat_be),
    .pre_en   (pre_en),
    .pre_idx  (pre_word[DEPTH_LOG2-1:0]),
    .pre_data (instruction),
    .rd_en    (rd_en),
    .rd_zero  (!in_range),
    .rd_idx   (cur_word[DEPTH_LOG2-1:0]),
    .rd_data  (readdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_avalon_mem_responder.sv
`default_nettype none
// tb_avalon_mem_responder: two responders (WAIT_CYCLES 1 and 3) against a word-array model.
module tb_avalon_mem_responder;

  localparam int NW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int tests = 0;
  int fails = 0;

  logic        rst_s   [2];
  logic [31:0] addr_s  [2];
  logic        rd_s    [2];
  logic        wr_s    [2];
  logic [31:0] wd_s    [2];
  logic [3:0]  be_s    [2];
  logic        wait_s  [2];
  logic [31:0] rdat_s  [2];
  logic        pre_s   [2];
  logic [7:0]  paddr_s [2];
  logic [31:0] pword_s [2];
  logic        err_s   [2];

  logic [31:0] mem_m [2][NW];
  bit          err_m [2];

  avalon_mem_responder #(.DEPTH_LOG2(6), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .reset(rst_s[0]), .address(addr_s[0]), .read(rd_s[0]), .write(wr_s[0]),
    .writedata(wd_s[0]), .byteenable(be_s[0]), .waitrequest(wait_s[0]), .readdata(rdat_s[0]),
    .inst_input(pre_s[0]), .inst_addr(paddr_s[0]), .instruction(pword_s[0]), .protocol_err(err_s[0]));

  avalon_mem_responder #(.DEPTH_LOG2(6), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .reset(rst_s[1]), .address(addr_s[1]), .read(rd_s[1]), .write(wr_s[1]),
    .writedata(wd_s[1]), .byteenable(be_s[1]), .waitrequest(wait_s[1]), .readdata(rdat_s[1]),
    .inst_input(pre_s[1]), .inst_addr(paddr_s[1]), .instruction(pword_s[1]), .protocol_err(err_s[1]));

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic bit in_range(input logic [31:0] a);
    return (a >> 2) < NW;
  endfunction

  task automatic model_reset(input int d);
    for (int i = 0; i < NW; i++) mem_m[d][i] = '0;
    err_m[d] = 1'b0;
  endtask

  task automatic model_xfer(input int d, input bit r, input bit w, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be, output logic [31:0] exp_rd);
    int idx;
    exp_rd = '0;
    if (!in_range(a) || (r && w)) err_m[d] = 1'b1;
    if (in_range(a)) begin
      idx = int'(a >> 2);
      if (w) begin
        for (int b = 0; b < 4; b++) if (be[b]) mem_m[d][idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        exp_rd = mem_m[d][idx];
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input int d, input bit r, input bit w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be,
                      output logic [31:0] rdata, output int stalls, output int done_cyc);
    stalls = 0;
    addr_s[d] = a; rd_s[d] = r; wr_s[d] = w; wd_s[d] = wd; be_s[d] = be;
    #1;
    while (wait_s[d] !== 1'b0 && stalls < 40) begin
      stalls++;
      tick();
    end
    if (stalls >= 40) begin
      tests++; fails++;
      $display("FAIL xfer_timeout dut%0d: waitrequest=%b after %0d cycles, required 0", d, wait_s[d], stalls);
    end
    rdata = rdat_s[d];
    done_cyc = cycle;
    tick();
    rd_s[d] = 1'b0; wr_s[d] = 1'b0;
  endtask

  task automatic preload(input int d, input logic [7:0] a, input logic [31:0] word);
    pre_s[d] = 1'b1; paddr_s[d] = a; pword_s[d] = word;
    tick();
    pre_s[d] = 1'b0;
    mem_m[d][a >> 2] = word;
  endtask

  task automatic pulse_reset(input int d);
    rd_s[d] = 1'b0; wr_s[d] = 1'b0; pre_s[d] = 1'b0;
    rst_s[d] = 1'b1;
    tick();
    rst_s[d] = 1'b0;
    model_reset(d);
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; rd_s[d] = 1'b0; wr_s[d] = 1'b0; pre_s[d] = 1'b0;
      addr_s[d] = '0; wd_s[d] = '0; be_s[d] = '0; paddr_s[d] = '0; pword_s[d] = '0;
      model_reset(d);
    end
    repeat (2) @(posedge clk);
    #1;
    rd_s[0] = 1'b1;
    #1;
    tests++; if (wait_s[0] !== 1'b1) begin fails++; $display("FAIL reset_wait_req: got %b required 1", wait_s[0]); end
    tests++; if (wait_s[1] !== 1'b0) begin fails++; $display("FAIL reset_wait_idle: got %b required 0", wait_s[1]); end
    for (int d = 0; d < 2; d++) begin
      tests++; if (rdat_s[d] !== 32'h0) begin fails++; $display("FAIL reset_readdata dut%0d: got %h required 0", d, rdat_s[d]); end
      tests++; if (err_s[d] !== 1'b0) begin fails++; $display("FAIL reset_err dut%0d: got %b required 0", d, err_s[d]); end
    end
    rd_s[0] = 1'b0;
    tick();
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    tick();
  endtask

  task automatic test_preload_read;
    logic [31:0] rd, exp;
    int st, dc;
    for (int d = 0; d < 2; d++) begin
      preload(d, 8'h04, 32'h2402_0010);
      preload(d, 8'h08, 32'h1C60_0002);
    end
    xfer(0, 1'b1, 1'b0, 32'h04, '0, 4'h0, rd, st, dc);
    model_xfer(0, 1'b1, 1'b0, 32'h04, '0, 4'h0, exp);
    tests++; if (st != 1) begin fails++; $display("FAIL preload_read_stalls: got %0d required 1", st); end
    tests++; if (rd !== exp) begin fails++; $display("FAIL preload_read_data: got %h required %h", rd, exp); end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] rd, exp;
    int st, dc;
    xfer(1, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b0101, rd, st, dc);
    model_xfer(1, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b0101, exp);
    tests++; if (st != 3) begin fails++; $display("FAIL lanes_write_stalls: got %0d required 3", st); end
    xfer(1, 1'b1, 1'b0, 32'h10, '0, 4'h0, rd, st, dc);
    model_xfer(1, 1'b1, 1'b0, 32'h10, '0, 4'h0, exp);
    tests++; if (st != 3) begin fails++; $display("FAIL lanes_read_stalls: got %0d required 3", st); end
    tests++; if (rd !== exp) begin fails++; $display("FAIL lanes_read_data: got %h required %h", rd, exp); end
    xfer(1, 1'b0, 1'b1, 32'h10, 32'h1234_5678, 4'b0000, rd, st, dc);
    model_xfer(1, 1'b0, 1'b1, 32'h10, 32'h1234_5678, 4'b0000, exp);
    xfer(1, 1'b1, 1'b0, 32'h10, '0, 4'hF, rd, st, dc);
    model_xfer(1, 1'b1, 1'b0, 32'h10, '0, 4'hF, exp);
    tests++; if (rd !== exp) begin fails++; $display("FAIL lanes_be0_data: got %h required %h", rd, exp); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd1, rd2, e1, e2;
    int s1, s2, c1, c2;
    for (int d = 0; d < 2; d++) begin
      xfer(d, 1'b1, 1'b0, 32'h04, '0, 4'h0, rd1, s1, c1);
      xfer(d, 1'b1, 1'b0, 32'h08, '0, 4'h0, rd2, s2, c2);
      model_xfer(d, 1'b1, 1'b0, 32'h04, '0, 4'h0, e1);
      model_xfer(d, 1'b1, 1'b0, 32'h08, '0, 4'h0, e2);
      tests++; if (c2 - c1 != wait_of(d) + 1) begin fails++; $display("FAIL b2b_spacing dut%0d: got %0d required %0d", d, c2 - c1, wait_of(d) + 1); end
      tests++; if (rd1 !== e1) begin fails++; $display("FAIL b2b_data0 dut%0d: got %h required %h", d, rd1, e1); end
      tests++; if (rd2 !== e2) begin fails++; $display("FAIL b2b_data1 dut%0d: got %h required %h", d, rd2, e2); end
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, exp, a, wd;
    logic [3:0]  be;
    int kind, st, dc;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 30; n++) begin
        kind = int'($urandom_range(0, 4));
        a    = $urandom_range(0, 255);
        wd   = $urandom;
        be   = 4'($urandom_range(0, 15));
        if (kind == 0) begin
          preload(d, a[7:0], wd);
        end else begin
          xfer(d, kind >= 3, kind < 3, a, wd, be, rd, st, dc);
          model_xfer(d, kind >= 3, kind < 3, a, wd, be, exp);
          tests++; if (st != wait_of(d)) begin fails++; $display("FAIL rand_stalls dut%0d n%0d: got %0d required %0d", d, n, st, wait_of(d)); end
          if (kind >= 3) begin
            tests++; if (rd !== exp) begin fails++; $display("FAIL rand_read dut%0d addr %h: got %h required %h", d, a, rd, exp); end
          end
          tests++; if (err_s[d] !== err_m[d]) begin fails++; $display("FAIL rand_err dut%0d: got %b required %b", d, err_s[d], err_m[d]); end
        end
      end
    end
  endtask

  task automatic test_preload_priority;
    logic [31:0] rd, exp;
    int st, dc;
    addr_s[0] = 32'h30; wr_s[0] = 1'b1; rd_s[0] = 1'b0; wd_s[0] = 32'hAAAA_AAAA; be_s[0] = 4'hF;
    tick();
    pre_s[0] = 1'b1; paddr_s[0] = 8'h30; pword_s[0] = 32'h5555_5555;
    tick();
    pre_s[0] = 1'b0; wr_s[0] = 1'b0;
    model_xfer(0, 1'b0, 1'b1, 32'h30, 32'hAAAA_AAAA, 4'hF, exp);
    mem_m[0][12] = 32'h5555_5555;
    xfer(0, 1'b1, 1'b0, 32'h30, '0, 4'h0, rd, st, dc);
    model_xfer(0, 1'b1, 1'b0, 32'h30, '0, 4'h0, exp);
    tests++; if (rd !== exp) begin fails++; $display("FAIL preload_priority: got %h required %h", rd, exp); end
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd, exp;
    int st, dc;
    tests++; if (err_s[0] !== 1'b0) begin fails++; $display("FAIL oor_err_before: got %b required 0", err_s[0]); end
    xfer(0, 1'b1, 1'b0, 32'h400, '0, 4'hF, rd, st, dc);
    model_xfer(0, 1'b1, 1'b0, 32'h400, '0, 4'hF, exp);
    tests++; if (st != 1) begin fails++; $display("FAIL oor_stalls: got %0d required 1", st); end
    tests++; if (rd !== exp) begin fails++; $display("FAIL oor_read_data: got %h required %h", rd, exp); end
    tests++; if (err_s[0] !== err_m[0]) begin fails++; $display("FAIL oor_err_set: got %b required %b", err_s[0], err_m[0]); end
    xfer(0, 1'b0, 1'b1, 32'h404, 32'hFFFF_FFFF, 4'hF, rd, st, dc);
    model_xfer(0, 1'b0, 1'b1, 32'h404, 32'hFFFF_FFFF, 4'hF, exp);
    xfer(0, 1'b1, 1'b0, 32'h04, '0, 4'h0, rd, st, dc);
    model_xfer(0, 1'b1, 1'b0, 32'h04, '0, 4'h0, exp);
    tests++; if (rd !== exp) begin fails++; $display("FAIL oor_after_read: got %h required %h", rd, exp); end
    tests++; if (err_s[0] !== 1'b1) begin fails++; $display("FAIL oor_err_sticky: got %b required 1", err_s[0]); end
  endtask

  task automatic test_read_write_both;
    logic [31:0] rd, exp;
    int st, dc;
    tests++; if (err_s[1] !== 1'b0) begin fails++; $display("FAIL rw_err_before: got %b required 0", err_s[1]); end
    xfer(1, 1'b1, 1'b1, 32'h20, 32'h1122_3344, 4'hF, rd, st, dc);
    model_xfer(1, 1'b1, 1'b1, 32'h20, 32'h1122_3344, 4'hF, exp);
    tests++; if (err_s[1] !== err_m[1]) begin fails++; $display("FAIL rw_err_set: got %b required %b", err_s[1], err_m[1]); end
    xfer(1, 1'b1, 1'b0, 32'h20, '0, 4'h0, rd, st, dc);
    model_xfer(1, 1'b1, 1'b0, 32'h20, '0, 4'h0, exp);
    tests++; if (rd !== exp) begin fails++; $display("FAIL rw_written: got %h required %h", rd, exp); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd, exp;
    int st, dc;
    preload(1, 8'h0C, 32'hCAFE_F00D);
    xfer(1, 1'b1, 1'b0, 32'h0C, '0, 4'h0, rd, st, dc);
    model_xfer(1, 1'b1, 1'b0, 32'h0C, '0, 4'h0, exp);
    tests++; if (rd !== exp) begin fails++; $display("FAIL rmid_pre_read: got %h required %h", rd, exp); end
    addr_s[1] = 32'h0C; wr_s[1] = 1'b1; wd_s[1] = 32'h7777_1111; be_s[1] = 4'hF;
    tick();
    #2 rst_s[1] = 1'b1;
    #1;
    tests++; if (rdat_s[1] !== 32'h0) begin fails++; $display("FAIL rmid_async_readdata: got %h required 0", rdat_s[1]); end
    wr_s[1] = 1'b0;
    tick();
    rst_s[1] = 1'b0;
    model_reset(1);
    xfer(1, 1'b1, 1'b0, 32'h0C, '0, 4'h0, rd, st, dc);
    model_xfer(1, 1'b1, 1'b0, 32'h0C, '0, 4'h0, exp);
    tests++; if (rd !== exp) begin fails++; $display("FAIL rmid_read_after: got %h required %h", rd, exp); end
    tests++; if (err_s[1] !== 1'b0) begin fails++; $display("FAIL rmid_err: got %b required 0", err_s[1]); end
  endtask

  task automatic test_abort;
    logic [31:0] rd, exp;
    int st, dc, k;
    addr_s[1] = 32'h24; wr_s[1] = 1'b1; wd_s[1] = 32'h1234_5678; be_s[1] = 4'hF;
    tick();
    wr_s[1] = 1'b0;
    tick();
    tests++; if (err_s[1] !== 1'b1) begin fails++; $display("FAIL abort_err: got %b required 1", err_s[1]); end
    xfer(1, 1'b1, 1'b0, 32'h24, '0, 4'h0, rd, st, dc);
    model_xfer(1, 1'b1, 1'b0, 32'h24, '0, 4'h0, exp);
    tests++; if (rd !== exp) begin fails++; $display("FAIL abort_no_write: got %h required %h", rd, exp); end
    pulse_reset(1);
    addr_s[1] = 32'h28; wr_s[1] = 1'b1; wd_s[1] = 32'h0BAD_CAFE; be_s[1] = 4'hF;
    tick();
    addr_s[1] = 32'h2C;
    k = 0;
    while (wait_s[1] !== 1'b0 && k < 10) begin k++; tick(); end
    tests++; if (k >= 10) begin fails++; $display("FAIL addr_change_timeout: waitrequest=%b required 0", wait_s[1]); end
    tick();
    wr_s[1] = 1'b0;
    model_xfer(1, 1'b0, 1'b1, 32'h28, 32'h0BAD_CAFE, 4'hF, exp);
    err_m[1] = 1'b1;
    tests++; if (err_s[1] !== err_m[1]) begin fails++; $display("FAIL addr_change_err: got %b required %b", err_s[1], err_m[1]); end
    xfer(1, 1'b1, 1'b0, 32'h28, '0, 4'h0, rd, st, dc);
    model_xfer(1, 1'b1, 1'b0, 32'h28, '0, 4'h0, exp);
    tests++; if (rd !== exp) begin fails++; $display("FAIL addr_change_latched: got %h required %h", rd, exp); end
    xfer(1, 1'b1, 1'b0, 32'h2C, '0, 4'h0, rd, st, dc);
    model_xfer(1, 1'b1, 1'b0, 32'h2C, '0, 4'h0, exp);
    tests++; if (rd !== exp) begin fails++; $display("FAIL addr_change_other: got %h required %h", rd, exp); end
  endtask

  initial begin
    test_reset();
    test_preload_read();
    test_byte_lanes();
    test_back_to_back();
    test_random();
    test_preload_priority();
    test_out_of_range();
    test_read_write_both();
    test_reset_mid();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
